// File: rtl/regfile_debug_port.sv
// Debug command port that reads, writes, dumps and fills a register file through its client port.
// Latency: READ/DUMP word is captured one cycle after the command lands, then held until taken; writes are one register per cycle.
// Backpressure: cmd_ready only while idle; each response is held stable until rsp_ready, which stalls the walk.
module regfile_debug_port #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [AW-1:0] cmd_lo,
  input  logic [AW-1:0] cmd_hi,
  input  logic [DW-1:0] cmd_data,
  output logic [AW-1:0] rf_addrA,
  input  logic [DW-1:0] rf_readA,
  output logic [AW-1:0] rf_addrWrite,
  output logic [DW-1:0] rf_writeData,
  output logic          rf_RegWrite,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic [AW-1:0] rsp_addr,
  output logic          rsp_last,
  output logic          rsp_err
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RD   = 3'd1;
  localparam logic [2:0] RSP  = 3'd2;
  localparam logic [2:0] WR   = 3'd3;
  localparam logic [2:0] ACK  = 3'd4;

  // cmd_op[1] selects a range op, cmd_op[0] selects a write op
  logic [2:0]    state;
  logic [AW-1:0] cur;
  logic [AW-1:0] end_q;
  logic [AW-1:0] lo_q;
  logic [DW-1:0] data_q;
  logic [AW:0]   wr_count;

  // One extra bit so a full 0..2^AW-1 fill reports 2^AW rather than 0
  assign wr_count = {1'b0, end_q} - {1'b0, lo_q} + (AW+1)'(1);

  // Register-file client port always follows the walk pointer
  always_comb begin
    cmd_ready    = (state == IDLE) && !rst;
    rsp_valid    = (state == RSP) || (state == ACK);
    rf_RegWrite  = (state == WR);
    rf_addrA     = cur;
    rf_addrWrite = cur;
    rf_writeData = data_q;
  end

  // Command sequencing: capture on accept, walk cur from lo to end without wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cur      <= '0;
      end_q    <= '0;
      lo_q     <= '0;
      data_q   <= '0;
      rsp_data <= '0;
      rsp_addr <= '0;
      rsp_last <= 1'b0;
      rsp_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            cur    <= cmd_lo;
            lo_q   <= cmd_lo;
            end_q  <= cmd_op[1] ? cmd_hi : cmd_lo;
            data_q <= cmd_data;
            if (cmd_op[1] && (cmd_hi < cmd_lo)) begin
              // Inverted range: answer with an error and never touch the register file
              rsp_data <= '0;
              rsp_addr <= cmd_lo;
              rsp_last <= 1'b1;
              rsp_err  <= 1'b1;
              state    <= ACK;
            end else begin
              state <= cmd_op[0] ? WR : RD;
            end
          end
        end
        RD: begin
          rsp_data <= rf_readA;
          rsp_addr <= cur;
          rsp_last <= (cur == end_q);
          rsp_err  <= 1'b0;
          state    <= RSP;
        end
        RSP: begin
          if (rsp_ready) begin
            if (rsp_last) begin
              state <= IDLE;
            end else begin
              cur   <= cur + AW'(1);
              state <= RD;
            end
          end
        end
        WR: begin
          if (cur == end_q) begin
            rsp_data <= DW'(wr_count);
            rsp_addr <= end_q;
            rsp_last <= 1'b1;
            rsp_err  <= 1'b0;
            state    <= ACK;
          end else begin
            cur <= cur + AW'(1);
          end
        end
        ACK: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_debug_port.sv
// Randomized bench for regfile_debug_port with an array-based reference model.
// Expected responses and register writes are queued per command and popped at each handshake.
// Response stalls are produced by toggling rsp_ready at random.
module tb_regfile_debug_port;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'b00;
  logic [AW-1:0] cmd_lo = '0;
  logic [AW-1:0] cmd_hi = '0;
  logic [DW-1:0] cmd_data = '0;
  logic [AW-1:0] rf_addrA;
  logic [DW-1:0] rf_readA;
  logic [AW-1:0] rf_addrWrite;
  logic [DW-1:0] rf_writeData;
  logic          rf_RegWrite;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_data;
  logic [AW-1:0] rsp_addr;
  logic          rsp_last;
  logic          rsp_err;

  regfile_debug_port #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_lo(cmd_lo), .cmd_hi(cmd_hi), .cmd_data(cmd_data),
    .rf_addrA(rf_addrA), .rf_readA(rf_readA), .rf_addrWrite(rf_addrWrite),
    .rf_writeData(rf_writeData), .rf_RegWrite(rf_RegWrite),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_addr(rsp_addr), .rsp_last(rsp_last), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [DW-1:0] d; logic [AW-1:0] a; logic l; logic e; } rsp_t;
  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;

  rsp_t exp_rsp[$];
  wr_t  exp_wr[$];
  logic [DW-1:0] ref_mem [32];
  logic [DW-1:0] rf_mem  [32];
  int checks = 0;
  int failures = 0;
  int wr_cycles = 0;
  bit ready_mode = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Register file seen by the DUT: combinational read, write on the clock edge
  assign rf_readA = rf_mem[rf_addrA];
  initial begin
    for (int i = 0; i < 32; i++) begin
      rf_mem[i]  = $urandom;
      ref_mem[i] = rf_mem[i];
    end
    rf_mem[10]  = 32'd69;
    ref_mem[10] = 32'd69;
    forever begin
      @(posedge clk);
      if (rf_RegWrite) rf_mem[rf_addrWrite] <= rf_writeData;
    end
  end

  // rsp_ready either held high or toggled at random, changed just after each rising edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      rsp_ready = ready_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Reference model: expected outcome of one accepted command from the operation rules
  task automatic model_cmd(input logic [1:0] op, input int lo, input int hi, input logic [DW-1:0] d);
    rsp_t r;
    wr_t  w;
    if (!op[1]) hi = lo;
    if (hi < lo) begin
      r.d = '0; r.a = lo[AW-1:0]; r.l = 1'b1; r.e = 1'b1;
      exp_rsp.push_back(r);
    end else if (op[0]) begin
      for (int a = lo; a <= hi; a++) begin
        w.a = a[AW-1:0]; w.d = d;
        exp_wr.push_back(w);
        ref_mem[a] = d;
      end
      r.d = hi - lo + 1; r.a = hi[AW-1:0]; r.l = 1'b1; r.e = 1'b0;
      exp_rsp.push_back(r);
    end else begin
      for (int a = lo; a <= hi; a++) begin
        r.d = ref_mem[a]; r.a = a[AW-1:0]; r.l = (a == hi); r.e = 1'b0;
        exp_rsp.push_back(r);
      end
    end
  endtask

  // Monitor: inspect handshakes and writes mid-cycle, before the edge that commits them
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_d;
  logic [AW-1:0] prev_a;
  logic          prev_l;
  logic          prev_e;
  initial begin
    rsp_t r;
    wr_t  w;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid", rsp_valid, 1'b1);
          check("stall_data", rsp_data, prev_d);
          check("stall_addr", rsp_addr, prev_a);
          check("stall_last", rsp_last, prev_l);
          check("stall_err", rsp_err, prev_e);
        end
        if (rsp_valid && rsp_ready) begin
          check("rsp_expected", exp_rsp.size() != 0, 1'b1);
          if (exp_rsp.size() != 0) begin
            r = exp_rsp.pop_front();
            check("rsp_data", rsp_data, r.d);
            check("rsp_addr", rsp_addr, r.a);
            check("rsp_last", rsp_last, r.l);
            check("rsp_err", rsp_err, r.e);
          end
        end
        if (rf_RegWrite) begin
          wr_cycles++;
          check("wr_during_rsp", rsp_valid, 1'b0);
          check("wr_expected", exp_wr.size() != 0, 1'b1);
          if (exp_wr.size() != 0) begin
            w = exp_wr.pop_front();
            check("wr_addr", rf_addrWrite, w.a);
            check("wr_data", rf_writeData, w.d);
          end
        end
        prev_stall = rsp_valid && !rsp_ready;
        prev_d = rsp_data; prev_a = rsp_addr; prev_l = rsp_last; prev_e = rsp_err;
      end
    end
  end

  task automatic send_cmd(input logic [1:0] op, input logic [AW-1:0] lo, input logic [AW-1:0] hi,
                          input logic [DW-1:0] d);
    bit got = 1'b0;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1; cmd_op = op; cmd_lo = lo; cmd_hi = hi; cmd_data = d;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        got = 1'b1;
        model_cmd(op, int'(lo), int'(hi), d);
      end
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom); cmd_lo = AW'($urandom); cmd_hi = AW'($urandom); cmd_data = $urandom;
    check("cmd_accepted", got, 1'b1);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 3000 && (exp_rsp.size() != 0 || exp_wr.size() != 0); i++) @(negedge clk);
    check("drain", exp_rsp.size() + exp_wr.size(), 0);
  endtask

  initial begin
    int n;
    int base;
    int lo;
    int hi;
    logic [1:0] op;
    wr_t w;

    // Reset state
    #3;
    check("rst_cmd_ready", cmd_ready, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_regwrite", rf_RegWrite, 1'b0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_last", rsp_last, 1'b0);
    check("rst_rsp_err", rsp_err, 1'b0);
    @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("idle_cmd_ready", cmd_ready, 1'b1);

    // READ of register 10 and its response latency
    send_cmd(2'b00, 5'd10, 5'd0, '0);
    n = 0;
    for (int i = 0; i < 20 && !rsp_valid; i++) begin
      @(negedge clk);
      n++;
    end
    check("read_latency", n, 2);
    wait_done();

    // FILL 2..5: exactly four write cycles, then a count of 4
    base = wr_cycles;
    send_cmd(2'b11, 5'd2, 5'd5, 32'hA5);
    wait_done();
    check("fill_wr_cycles", wr_cycles - base, 4);

    // DUMP 0..4 with a stalling consumer
    ready_mode = 1'b1;
    send_cmd(2'b10, 5'd0, 5'd4, '0);
    wait_done();
    ready_mode = 1'b0;

    // DUMP at the top of the address space stops at the last register
    send_cmd(2'b10, 5'd30, 5'd31, '0);
    wait_done();
    check("top_no_wrap", rf_addrA, 5'd31);

    // Inverted range: single error response, no writes
    base = wr_cycles;
    send_cmd(2'b10, 5'd7, 5'd3, '0);
    wait_done();
    send_cmd(2'b11, 5'd9, 5'd1, 32'h1234);
    wait_done();
    check("bad_range_no_wr", wr_cycles - base, 0);

    // Command offered while busy waits for the next idle cycle
    ready_mode = 1'b1;
    send_cmd(2'b10, 5'd0, 5'd3, '0);
    send_cmd(2'b00, 5'd5, 5'd0, '0);
    wait_done();

    // Random mix of all four operations
    for (int k = 0; k < 40; k++) begin
      op = 2'($urandom_range(0, 3));
      lo = $urandom_range(0, 31);
      if ($urandom_range(0, 6) == 0) hi = $urandom_range(0, 31);
      else hi = lo + $urandom_range(0, 6);
      if (hi > 31) hi = 31;
      ready_mode = 1'($urandom_range(0, 1));
      send_cmd(op, lo[AW-1:0], hi[AW-1:0], $urandom);
      if ($urandom_range(0, 2) != 0) wait_done();
    end
    wait_done();
    ready_mode = 1'b0;

    // Reset in the middle of FILL 0..31: only registers 0..11 get written
    base = wr_cycles;
    for (int a = 0; a < 12; a++) begin
      w.a = a[AW-1:0]; w.d = 32'hCAFE0000;
      exp_wr.push_back(w);
      ref_mem[a] = 32'hCAFE0000;
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b1; cmd_op = 2'b11; cmd_lo = 5'd0; cmd_hi = 5'd31; cmd_data = 32'hCAFE0000;
    for (int i = 0; i < 50 && !cmd_ready; i++) @(negedge clk);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 100 && !(rf_RegWrite && rf_addrWrite == 5'd11); i++) begin
      @(negedge clk);
      n++;
    end
    check("fill_reached_11", rf_addrWrite, 5'd11);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_regwrite", rf_RegWrite, 1'b0);
    check("midrst_rsp_valid", rsp_valid, 1'b0);
    check("midrst_cmd_ready", cmd_ready, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_cmd_ready", cmd_ready, 1'b1);
    check("post_rst_rsp_valid", rsp_valid, 1'b0);
    check("midrst_wr_cycles", wr_cycles - base, 12);
    send_cmd(2'b00, 5'd11, 5'd0, '0);
    send_cmd(2'b00, 5'd12, 5'd0, '0);
    send_cmd(2'b10, 5'd10, 5'd13, '0);
    wait_done();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound so the run always ends
  initial begin
    #400000;
    failures++;
    $display("FAIL global_timeout got=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
